ac2_seq: RTL and testbench

AC2_SEQ -- requirements
Module: ac2_seq

---
 rtl/ac2_pkg.sv | 14 +
 rtl/ac2_seq.sv | 128 ++++++++++++
 tb/tb_ac2_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ac2_pkg.sv
// ac2 sequencer shared types and constants.
// State encoding and channel count used by ac2_seq.
package ac2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    ACC,
    DRAIN
  } state_t;

  localparam int NUM_CH = 4;

endpackage

// File: rtl/ac2_seq.sv
// Sequencer for the ac2 shift-accumulator: clears four channels,
// steps slice-major/channel-minor beats, then drains results.
module ac2_seq
  import ac2_pkg::*;
#(
  parameter int M    = 16,
  parameter int Pa   = 8,
  parameter int Pw   = 4,
  parameter int NS_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NS_W-1:0] n_slices,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            ac_valid,
  output logic            ac_cl_en,
  output logic [1:0]      ac_w_en,
  output logic            res_valid,
  output logic [1:0]      res_sel,
  input  logic            res_ready,
  output logic            busy,
  output logic            done
);

  // M, Pa and Pw size the datapath this block steers; reject
  // nonsensical values at elaboration.
  if (M < 1 || Pa < 1 || Pw < 1 || NS_W < 1) begin : g_chk
    $error("ac2_seq: parameters must be positive");
  end

  localparam logic [1:0] CH_LAST = 2'(NUM_CH - 1);

  state_t          state_q, state_d;
  logic [1:0]      ch_q, ch_d;
  logic [NS_W-1:0] sl_q, sl_d;
  logic [NS_W-1:0] ns_q, ns_d;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      sl_q    <= '0;
      ns_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      sl_q    <= sl_d;
      ns_q    <= ns_d;
    end
  end

  // Next-state, counter update and output decode.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    sl_d      = sl_q;
    ns_d      = ns_q;
    in_ready  = 1'b0;
    ac_valid  = 1'b0;
    ac_cl_en  = 1'b0;
    ac_w_en   = 2'd0;
    res_valid = 1'b0;
    res_sel   = 2'd0;
    done      = 1'b0;
    busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ns_d    = (n_slices == '0) ? NS_W'(1) : n_slices;
          ch_d    = 2'd0;
          sl_d    = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        ac_cl_en = 1'b1;
        ac_w_en  = ch_q;
        ch_d     = ch_q + 2'd1;
        if (ch_q == CH_LAST) state_d = ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        ac_w_en  = ch_q;
        ac_valid = in_valid;
        if (in_valid) begin
          ch_d = ch_q + 2'd1;
          if (ch_q == CH_LAST) begin
            if (sl_q == ns_q - NS_W'(1)) begin
              sl_d    = '0;
              ch_d    = 2'd0;
              state_d = DRAIN;
            end else begin
              sl_d = sl_q + NS_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        res_valid = 1'b1;
        res_sel   = ch_q;
        if (res_ready) begin
          ch_d = ch_q + 2'd1;
          if (ch_q == CH_LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase

    // Outputs stay quiet while reset is asserted.
    if (rst) begin
      in_ready  = 1'b0;
      ac_valid  = 1'b0;
      ac_cl_en  = 1'b0;
      ac_w_en   = 2'd0;
      res_valid = 1'b0;
      res_sel   = 2'd0;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_ac2_seq.sv
// Directed bench for ac2_seq: vector table plus
// hand sequences for full job, zero slices and mid-job reset.
module tb_ac2_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] n_slices;
  logic       in_valid;
  logic       in_ready;
  logic       ac_valid;
  logic       ac_cl_en;
  logic [1:0] ac_w_en;
  logic       res_valid;
  logic [1:0] res_sel;
  logic       res_ready;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_bad = 0;

  ac2_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .n_slices(n_slices), .in_valid(in_valid),
    .in_ready(in_ready), .ac_valid(ac_valid),
    .ac_cl_en(ac_cl_en), .ac_w_en(ac_w_en),
    .res_valid(res_valid), .res_sel(res_sel),
    .res_ready(res_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] ns;
    logic       iv;
    logic       rr;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [9:0] o(
    logic ir, logic av, logic cl, logic [1:0] wen,
    logic rv, logic [1:0] rs, logic b, logic d);
    return {ir, av, cl, wen, rv, rs, b, d};
  endfunction

  function automatic vec_t mk(
    logic r, logic s, logic [3:0] ns, logic iv,
    logic rr, logic [9:0] e);
    vec_t v;
    v.rst = r; v.start = s; v.ns = ns;
    v.iv = iv; v.rr = rr; v.exp = e;
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {in_ready, ac_valid, ac_cl_en, ac_w_en,
            res_valid, res_sel, busy, done};
  endfunction

  task automatic chk(string nm, logic [9:0] act, logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_i(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  localparam logic [9:0] Z = 10'd0;

  initial begin
    int cyc, nb, ndone, ovl;
    bit fin;
    logic [1:0] wq[8];
    logic [1:0] wexp[8];

    rst = 1'b1; start = 1'b0; n_slices = '0;
    in_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk);

    // rst, start, ns, iv, rr | ir av cl wen rv rs busy done
    tbl.push_back(mk(1,0,0,0,0, Z));
    tbl.push_back(mk(1,0,0,0,0, Z));
    tbl.push_back(mk(0,0,0,0,0, Z));
    tbl.push_back(mk(0,1,2,0,0, Z));
    tbl.push_back(mk(0,0,0,0,0, o(0,0,1,0,0,0,1,0)));
    tbl.push_back(mk(0,0,0,1,0, o(0,0,1,1,0,0,1,0)));
    tbl.push_back(mk(0,0,0,0,0, o(0,0,1,2,0,0,1,0)));
    tbl.push_back(mk(0,0,0,0,0, o(0,0,1,3,0,0,1,0)));
    tbl.push_back(mk(0,0,0,1,0, o(1,1,0,0,0,0,1,0)));
    tbl.push_back(mk(0,0,0,0,0, o(1,0,0,1,0,0,1,0)));
    tbl.push_back(mk(0,0,0,1,0, o(1,1,0,1,0,0,1,0)));
    tbl.push_back(mk(0,1,3,0,0, o(1,0,0,2,0,0,1,0)));
    tbl.push_back(mk(0,0,0,1,0, o(1,1,0,2,0,0,1,0)));
    tbl.push_back(mk(0,0,0,1,0, o(1,1,0,3,0,0,1,0)));
    tbl.push_back(mk(0,0,0,1,0, o(1,1,0,0,0,0,1,0)));
    tbl.push_back(mk(0,0,0,1,0, o(1,1,0,1,0,0,1,0)));
    tbl.push_back(mk(0,0,0,1,0, o(1,1,0,2,0,0,1,0)));
    tbl.push_back(mk(0,0,0,1,0, o(1,1,0,3,0,0,1,0)));
    tbl.push_back(mk(0,0,0,0,0, o(0,0,0,0,1,0,1,0)));
    tbl.push_back(mk(0,1,0,0,0, o(0,0,0,0,1,0,1,0)));
    tbl.push_back(mk(0,0,0,0,0, o(0,0,0,0,1,0,1,0)));
    tbl.push_back(mk(0,0,0,0,1, o(0,0,0,0,1,0,1,0)));
    tbl.push_back(mk(0,0,0,0,1, o(0,0,0,0,1,1,1,0)));
    tbl.push_back(mk(0,0,0,0,1, o(0,0,0,0,1,2,1,0)));
    tbl.push_back(mk(0,1,0,0,1, o(0,0,0,0,1,3,1,1)));
    tbl.push_back(mk(0,0,0,0,0, Z));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; start = tbl[i].start;
      n_slices = tbl[i].ns; in_valid = tbl[i].iv;
      res_ready = tbl[i].rr;
      #1;
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Full 2-slice job with no stalls.
    wexp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    @(negedge clk);
    start = 1'b1; n_slices = 4'd2;
    in_valid = 1'b1; res_ready = 1'b1;
    #1;
    cyc = 1; nb = 0; ndone = 0; ovl = 0; fin = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      cyc++;
      if (ac_valid) begin
        if (nb < 8) wq[nb] = ac_w_en;
        nb++;
      end
      if (ac_cl_en && ac_valid) ovl++;
      if (done) begin
        ndone++;
        fin = 1'b1;
      end
    end
    chk_i("job_len", cyc, 17);
    chk_i("job_beats", nb, 8);
    chk_i("job_done", ndone, 1);
    chk_i("job_overlap", ovl, 0);
    for (int i = 0; i < 8; i++)
      chk_i($sformatf("job_wen%0d", i), int'(wq[i]), int'(wexp[i]));
    @(negedge clk);
    #1;
    chk("job_idle", outs(), Z);

    // n_slices=0 acts as one slice; start during the job is ignored.
    @(negedge clk);
    start = 1'b1; n_slices = 4'd0;
    in_valid = 1'b1; res_ready = 1'b1;
    #1;
    nb = 0; fin = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      #1;
      if (ac_valid) begin
        if (nb < 8) wq[nb] = ac_w_en;
        nb++;
      end
      if (res_valid) fin = 1'b1;
    end
    start = 1'b0;
    chk_i("zero_beats", nb, 4);
    for (int i = 0; i < 4; i++)
      chk_i($sformatf("zero_wen%0d", i), int'(wq[i]), i);
    ndone = 0; fin = 1'b0;
    for (int k = 0; k < 10 && !fin; k++) begin
      @(negedge clk);
      #1;
      if (done) begin
        ndone++;
        fin = 1'b1;
      end
    end
    chk_i("zero_done", ndone, 1);
    @(negedge clk);
    #1;
    chk("zero_idle", outs(), Z);

    // Reset after beat 5 of a 2-slice job.
    @(negedge clk);
    start = 1'b1; n_slices = 4'd2;
    in_valid = 1'b1; res_ready = 1'b0;
    #1;
    nb = 0;
    for (int k = 0; k < 40 && nb < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (ac_valid) nb++;
    end
    chk_i("mid_beats", nb, 5);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("mid_in_rst", outs(), Z);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_idle", outs(), Z);
    @(negedge clk);
    start = 1'b1; n_slices = 4'd1;
    #1;
    chk("mid_start", outs(), Z);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("mid_clr0", outs(), o(0,0,1,0,0,0,1,0));
    @(negedge clk);
    #1;
    chk("mid_clr1", outs(), o(0,0,1,1,0,0,1,0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
